// File: rtl/seq_mult8_ctrl_if.sv
// rtl/seq_mult8_ctrl_if.sv - start/done request bus of the sequential multiplier
interface seq_mult8_ctrl_if #(
   parameter int WIDTH = 8
);
   logic               start;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] product;

   modport master (
      output start,
      output a,
      output b,
      input  busy,
      input  done,
      input  product
   );

   modport slave (
      input  start,
      input  a,
      input  b,
      output busy,
      output done,
      output product
   );
endinterface

// File: rtl/seq_mult8_ctrl.sv
// rtl/seq_mult8_ctrl.sv - shift-and-add 8x8 multiplier sequencer around an external adder
module seq_mult8_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   seq_mult8_ctrl_if.slave  bus,
   output logic [WIDTH-1:0] add_x,
   output logic [WIDTH-1:0] add_y,
   output logic             add_c0,
   input  logic [WIDTH-1:0] add_s,
   input  logic             add_c8
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] LAST = 4'(WIDTH - 1);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   mq;
   logic [WIDTH-1:0]   mcand;
   logic [3:0]         count;
   logic [2*WIDTH-1:0] product;
   logic               busy;
   logic               done;

   // The adder always sees the accumulator; the multiplicand is only
   // presented while iterating and the current multiplier bit is set.
   assign add_x  = acc;
   assign add_y  = (state == CALC && mq[0]) ? mcand : '0;
   assign add_c0 = 1'b0;

   assign bus.busy    = busy;
   assign bus.done    = done;
   assign bus.product = product;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake outputs; start is only honoured in IDLE.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (count == LAST) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: operand capture, one shift-add step per CALC cycle, result latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         mq      <= '0;
         mcand   <= '0;
         count   <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  mcand <= bus.a;
                  mq    <= bus.b;
                  acc   <= '0;
                  count <= '0;
               end
            end
            CALC: begin
               // {carry, sum, mq} shifted right by one: carry lands in the
               // accumulator MSB and the sum LSB moves into the multiplier.
               acc   <= {add_c8, add_s[WIDTH-1:1]};
               mq    <= {add_s[0], mq[WIDTH-1:1]};
               count <= count + 4'd1;
            end
            DONE: begin
               product <= {acc, mq};
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult8_ctrl.sv
// tb/tb_seq_mult8_ctrl.sv - randomized and directed checks of seq_mult8_ctrl against a*b
module tb_seq_mult8_ctrl;

   logic       clk;
   logic       rst_n;
   logic [7:0] add_x;
   logic [7:0] add_y;
   logic       add_c0;
   logic [7:0] add_s;
   logic       add_c8;

   int n_cmp;
   int n_err;

   seq_mult8_ctrl_if #(.WIDTH(8)) bus ();

   seq_mult8_ctrl #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .add_x  (add_x),
      .add_y  (add_y),
      .add_c0 (add_c0),
      .add_s  (add_s),
      .add_c8 (add_c8)
   );

   // Behavioural stand-in for the external 8-bit adder.
   assign {add_c8, add_s} = {1'b0, add_x} + {1'b0, add_y} + {8'd0, add_c0};

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One pulsed request; checks busy length, done latency and the product.
   task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input string tag);
      int  busy_n;
      int  lat;
      bit  seen;
      logic [15:0] exp_p;
      exp_p = 16'(av) * 16'(bv);
      @(negedge clk);
      bus.a     = av;
      bus.b     = bv;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      busy_n = 0;
      lat    = 0;
      seen   = 1'b0;
      for (int i = 1; i <= 30 && !seen; i++) begin
         if (bus.busy) busy_n++;
         if (bus.done) begin
            seen = 1'b1;
            lat  = i;
         end
         @(negedge clk);
      end
      check({tag, " done_latency"}, 32'(lat), 32'd9);
      check({tag, " busy_cycles"}, 32'(busy_n), 32'd8);
      check({tag, " product"}, 32'(bus.product), 32'(exp_p));
   endtask

   initial begin
      int          dq[$];
      logic [15:0] pq[$];
      int          ndone;
      logic [7:0]  ra;
      logic [7:0]  rb;

      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(negedge clk);
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check("reset product", 32'(bus.product), 32'd0);
      rst_n = 1'b1;

      // Basic multiply.
      run_op(8'h60, 8'h7F, "basic");

      // Back-to-back with start held high; operands swapped mid-operation.
      @(negedge clk);
      bus.a     = 8'hFF;
      bus.b     = 8'hFE;
      bus.start = 1'b1;
      @(negedge clk);
      bus.a = 8'hAA;
      bus.b = 8'h55;
      for (int i = 1; i <= 25; i++) begin
         if (dq.size() > 0 && i == dq[dq.size()-1] + 1) pq.push_back(bus.product);
         if (bus.done) dq.push_back(i);
         if (i == 11) bus.start = 1'b0;
         @(negedge clk);
      end
      check("b2b done_count", 32'(dq.size()), 32'd2);
      if (dq.size() == 2) begin
         check("b2b first_done", 32'(dq[0]), 32'd9);
         check("b2b spacing", 32'(dq[1] - dq[0]), 32'd10);
      end
      check("b2b product_count", 32'(pq.size()), 32'd2);
      if (pq.size() == 2) begin
         check("b2b product0", 32'(pq[0]), 32'h0000FD02);
         check("b2b product1", 32'(pq[1]), 32'h00003872);
      end

      // Zero and identity operands.
      run_op(8'h00, 8'hF0, "zero_a");
      run_op(8'h01, 8'h00, "zero_b");
      run_op(8'h08, 8'h81, "pow2");

      // Start while busy must be ignored.
      run_op(8'h00, 8'h00, "clear");
      @(negedge clk);
      bus.a     = 8'h08;
      bus.b     = 8'h81;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      ndone = 0;
      for (int i = 1; i <= 22; i++) begin
         if (i == 4) begin
            bus.a     = 8'hFF;
            bus.b     = 8'hFF;
            bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.done) ndone++;
         @(negedge clk);
      end
      check("busy_start done_count", 32'(ndone), 32'd1);
      check("busy_start product", 32'(bus.product), 32'h00000408);

      // Reset mid-operation.
      @(negedge clk);
      bus.a     = 8'hF0;
      bus.b     = 8'h88;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset busy", 32'(bus.busy), 32'd0);
      check("midreset done", 32'(bus.done), 32'd0);
      check("midreset product", 32'(bus.product), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         if (bus.done || bus.busy) ndone++;
         @(negedge clk);
      end
      check("postreset idle", 32'(ndone), 32'd0);
      run_op(8'hF0, 8'h88, "after_reset");

      // Randomized operands, occasionally forced to the edges.
      for (int k = 0; k < 16; k++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         if ($urandom_range(0, 5) == 0) ra = 8'hFF;
         if ($urandom_range(0, 5) == 0) rb = 8'h00;
         run_op(ra, rb, $sformatf("rand%0d", k));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "time limit");
   end

endmodule
